// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package addsub_seq_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_seq_ctrl_nibble_addsub.sv
// One 4-bit add/subtract slice; B is inverted when m is set so that cin = 1
// completes the two's complement on the first nibble.
module nibble_addsub
    import addsub_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a4,
    input  logic [NIB_W-1:0] b4,
    input  logic             m,
    input  logic             cin,
    output logic [NIB_W-1:0] s4,
    output logic             cout,
    output logic             c3
);

    logic [NIB_W-1:0] bx;
    logic [NIB_W-1:0] low;
    logic [1:0]       top;

    assign bx = b4 ^ {NIB_W{m}};

    // Split at bit 3 so the carry into the MSB is visible for overflow detection.
    assign low  = {1'b0, a4[NIB_W-2:0]} + {1'b0, bx[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};
    assign c3   = low[NIB_W-1];
    assign top  = {1'b0, a4[NIB_W-1]} + {1'b0, bx[NIB_W-1]} + {1'b0, c3};
    assign s4   = {top[0], low[NIB_W-2:0]};
    assign cout = top[1];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial W-bit adder/subtractor with valid/ready handshakes on both sides.
module addsub_seq_ctrl
    import addsub_seq_ctrl_pkg::*;
#(
    parameter int N_NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NIB_W*N_NIB-1:0] a,
    input  logic [NIB_W*N_NIB-1:0] b,
    input  logic                   m,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIB_W*N_NIB-1:0] s,
    output logic                   c,
    output logic                   v,
    output logic                   busy
);

    // One extra counter bit lets the count reach N_NIB without wrapping.
    localparam int CNT_W = $clog2(N_NIB + 1);
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    state_t state_q, state_d;

    logic [N_NIB-1:0][NIB_W-1:0] opA_q, opA_d;
    logic [N_NIB-1:0][NIB_W-1:0] opB_q, opB_d;
    logic [N_NIB-1:0][NIB_W-1:0] res_q, res_d;
    logic                        mode_q, mode_d;
    logic                        carry_q, carry_d;
    logic                        cOut_q, cOut_d;
    logic                        vOut_q, vOut_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [IDX_W-1:0] nibIdx;
    logic             lastNib;
    logic [NIB_W-1:0] nibSum;
    logic             nibCout;
    logic             nibC3;

    assign nibIdx  = cnt_q[IDX_W-1:0];
    assign lastNib = (cnt_q == CNT_W'(N_NIB - 1));

    nibble_addsub u_nibble (
        .a4   (opA_q[nibIdx]),
        .b4   (opB_q[nibIdx]),
        .m    (mode_q),
        .cin  (carry_q),
        .s4   (nibSum),
        .cout (nibCout),
        .c3   (nibC3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (lastNib)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opA_q   <= '0;
            opB_q   <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            cOut_q  <= 1'b0;
            vOut_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            cOut_q  <= cOut_d;
            vOut_q  <= vOut_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are captured once on accept, so input changes mid-operation are invisible.
    always_comb begin
        opA_d   = opA_q;
        opB_d   = opB_q;
        res_d   = res_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        cOut_d  = cOut_q;
        vOut_d  = vOut_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = a;
                    opB_d   = b;
                    mode_d  = m;
                    res_d   = '0;
                    carry_d = m;
                    cOut_d  = 1'b0;
                    vOut_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                res_d[nibIdx] = nibSum;
                carry_d       = nibCout;
                cnt_d         = cnt_q + CNT_W'(1);
                if (lastNib) begin
                    cOut_d = nibCout;
                    vOut_d = nibC3 ^ nibCout;
                end
            end
            default: ;
        endcase
    end

    assign s = res_q;
    assign c = cOut_q;
    assign v = vOut_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: directed corner cases plus random
// operands compared against an integer-arithmetic reference model.
module tb_addsub_seq_ctrl;

    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_seq_ctrl #(.N_NIB(N_NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .m         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c         (c),
        .v         (v),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Returns {v, c, s} from plain unsigned/signed integer arithmetic.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rm);
        longint ua, ub, sa, sb, ur, sr, hi, lo;
        logic [W-1:0] rs;
        logic rc, rv;
        ua = longint'(ra);
        ub = longint'(rb);
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        ur = rm ? (ua - ub) : (ua + ub);
        sr = rm ? (sa - sb) : (sa + sb);
        rs = ur[W-1:0];
        rc = rm ? (ua >= ub) : (ur > ((longint'(1) <<< W) - 1));
        rv = (sr > hi) || (sr < lo);
        return {rv, rc, rs};
    endfunction

    task automatic scrambleInputs();
        a        = W'($urandom);
        b        = W'($urandom);
        m        = 1'($urandom);
        in_valid = 1'($urandom);
    endtask

    // Issues one request from IDLE and leaves the DUT in DONE with the result checked.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tm, input string tag);
        logic [W+1:0] expv;
        expv = refModel(ta, tb2, tm);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb2;
        m        = tm;
        in_valid = 1'b1;
        tick();
        for (int i = 1; i <= N_NIB; i++) begin
            checkOutput({tag, "_run_out_valid"}, 32'(out_valid), 32'd0);
            checkOutput({tag, "_run_busy"}, 32'(busy), 32'd1);
            scrambleInputs();
            tick();
        end
        in_valid = 1'b0;
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_s"}, 32'(s), 32'(expv[W-1:0]));
        checkOutput({tag, "_c"}, 32'(c), 32'(expv[W]));
        checkOutput({tag, "_v"}, 32'(v), 32'(expv[W+1]));
    endtask

    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W+1:0] expv;
        logic [W+1:0] expQ[$];
        logic         acc;
        int           got;
        int           lastDel;

        // Reset with a pending request: reset must win.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        m         = 1'b1;
        tick();
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_s", 32'(s), 32'd0);
        checkOutput("reset_c", 32'(c), 32'd0);
        checkOutput("reset_v", 32'(v), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        applyStimulus(16'h1234, 16'h4321, 1'b0, "add_basic");
        checkOutput("add_basic_s_const", 32'(s), 32'h5555);
        releaseResult("add_basic");

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        checkOutput("add_ovf_s_const", 32'(s), 32'h8000);
        checkOutput("add_ovf_v_const", 32'(v), 32'd1);
        releaseResult("add_ovf");

        applyStimulus(16'h0000, 16'h0001, 1'b1, "sub_borrow");
        checkOutput("sub_borrow_s_const", 32'(s), 32'hFFFF);
        checkOutput("sub_borrow_c_const", 32'(c), 32'd0);
        releaseResult("sub_borrow");

        applyStimulus(16'h8000, 16'h0001, 1'b1, "sub_ovf");
        checkOutput("sub_ovf_s_const", 32'(s), 32'h7FFF);
        checkOutput("sub_ovf_c_const", 32'(c), 32'd1);
        checkOutput("sub_ovf_v_const", 32'(v), 32'd1);

        // Hold DONE with a competing request; the result must stay put.
        expv = refModel(16'h8000, 16'h0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            m        = 1'($urandom);
            tick();
            checkOutput("hold_s", 32'(s), 32'(expv[W-1:0]));
            checkOutput("hold_c", 32'(c), 32'(expv[W]));
            checkOutput("hold_v", 32'(v), 32'(expv[W+1]));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("hold_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("hold_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("hold_release_busy", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        // Abort during the second RUN cycle.
        a        = 16'h1111;
        b        = 16'h2222;
        m        = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_s", 32'(s), 32'd0);
        checkOutput("abort_c", 32'(c), 32'd0);
        checkOutput("abort_v", 32'(v), 32'd0);
        applyStimulus(16'hA5A5, 16'h5A5B, 1'b1, "after_abort");
        releaseResult("after_abort");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), "random");
            releaseResult("random");
        end

        // Back-to-back stream with the consumer always ready.
        got       = 0;
        lastDel   = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        m         = 1'($urandom);
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("b2b_unexpected_result", 32'd1, 32'd0);
                end else begin
                    expv = expQ.pop_front();
                    checkOutput("b2b_s", 32'(s), 32'(expv[W-1:0]));
                    checkOutput("b2b_c", 32'(c), 32'(expv[W]));
                    checkOutput("b2b_v", 32'(v), 32'(expv[W+1]));
                end
                if (lastDel >= 0) begin
                    checkOutput("b2b_spacing", 32'(cyc - lastDel), 32'(N_NIB + 2));
                end
                lastDel = cyc;
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) expQ.push_back(refModel(a, b, m));
            tick();
            if (acc) begin
                a = W'($urandom);
                b = W'($urandom);
                m = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        checkOutput("b2b_count", 32'(got), 32'd8);
        checkOutput("b2b_leftover", 32'(expQ.size()), 32'd0);
        tick();
        checkOutput("b2b_final_idle", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
